// File: rtl/dmem_wait_ctrl.sv
// Data memory with req/ready handshake and configurable wait states.
// Byte/halfword/word access, sign/zero extension, alignment and range checks.
module dmem_wait_ctrl #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_write_data,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  error,
    output logic                  busy
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [AW-1:0]         idx_q;
    logic [1:0]            lane_q;
    logic [1:0]            size_q;
    logic                  sgn_q;
    logic                  wr_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  ready_q;
    logic                  error_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic [31:0]           offset;
    logic                  oob_in;
    logic                  misal_in;
    logic                  err_in;
    logic                  start;
    logic                  commit;

    logic [AW-1:0]         cur_idx;
    logic [1:0]            cur_lane;
    logic [1:0]            cur_size;
    logic                  cur_sgn;
    logic                  cur_wr;
    logic                  cur_err;
    logic [DATA_WIDTH-1:0] cur_wdata;

    logic [NB-1:0]         be_d;
    logic [DATA_WIDTH-1:0] wlane_d;
    logic [DATA_WIDTH-1:0] rshift;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        offset = req_addr - BASE_ADDR;
        oob_in = (req_addr < BASE_ADDR) ||
                 ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS));
        misal_in = 1'b0;
        unique case (req_size)
            2'b00:   misal_in = 1'b0;
            2'b01:   misal_in = offset[0];
            2'b10:   misal_in = (offset[1:0] != 2'b00);
            default: misal_in = 1'b1;
        endcase
        err_in = oob_in || misal_in || (req_read && req_write);
    end

    assign start = (state_q == S_IDLE) && (req_read || req_write);

    // With no wait states the commit edge is the sampling edge itself,
    // so the access is served straight from the request inputs.
    assign commit = (WAIT_STATES == 0) ? start :
                    ((state_q == S_WAIT) && (cnt_q == 4'd0));

    always_comb begin
        if (state_q == S_IDLE) begin
            cur_idx   = offset[AW+1:2];
            cur_lane  = offset[1:0];
            cur_size  = req_size;
            cur_sgn   = req_signed;
            cur_wr    = req_write;
            cur_err   = err_in;
            cur_wdata = req_write_data;
        end else begin
            cur_idx   = idx_q;
            cur_lane  = lane_q;
            cur_size  = size_q;
            cur_sgn   = sgn_q;
            cur_wr    = wr_q;
            cur_err   = err_q;
            cur_wdata = wdata_q;
        end
    end

    always_comb begin
        be_d    = '0;
        wlane_d = cur_wdata;
        unique case (cur_size)
            2'b00: begin
                be_d    = NB'(1) << cur_lane;
                wlane_d = {NB{cur_wdata[7:0]}};
            end
            2'b01: begin
                be_d    = NB'(3) << cur_lane;
                wlane_d = {(NB/2){cur_wdata[15:0]}};
            end
            2'b10: begin
                be_d    = '1;
                wlane_d = cur_wdata;
            end
            default: begin
                be_d    = '0;
                wlane_d = cur_wdata;
            end
        endcase
    end

    always_comb begin
        rshift  = mem_q[cur_idx] >> {cur_lane, 3'b000};
        rdata_d = '0;
        unique case (cur_size)
            2'b00: rdata_d = {{(DATA_WIDTH-8){cur_sgn & rshift[7]}},
                              rshift[7:0]};
            2'b01: rdata_d = {{(DATA_WIDTH-16){cur_sgn & rshift[15]}},
                              rshift[15:0]};
            2'b10: rdata_d = rshift;
            default: rdata_d = '0;
        endcase
        if (cur_err || cur_wr) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && commit && cur_wr && !cur_err) begin
            for (int b = 0; b < NB; b++) begin
                if (be_d[b]) begin
                    mem_q[cur_idx][8*b +: 8] <= wlane_d[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        idx_q   <= offset[AW+1:2];
                        lane_q  <= offset[1:0];
                        size_q  <= req_size;
                        sgn_q   <= req_signed;
                        wr_q    <= req_write;
                        err_q   <= err_in;
                        wdata_q <= req_write_data;
                        busy_q  <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b1;
                            error_q <= err_in;
                            rdata_q <= rdata_d;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_DONE;
                        ready_q <= 1'b1;
                        error_q <= err_q;
                        rdata_q <= rdata_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                    busy_q  <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                    busy_q  <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign error     = error_q;
    assign busy      = busy_q;
    assign read_data = rdata_q;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed scoreboard bench for dmem_wait_ctrl.
// Two instances: two wait states and zero wait states.
module tb_dmem_wait_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic        rd2, wr2, rd0, wr0;
    logic        ready2, err2, busy2;
    logic        ready0, err0, busy0;
    logic [31:0] data2, data0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    dmem_wait_ctrl #(
        .DATA_WIDTH(32), .DEPTH_WORDS(1024),
        .WAIT_STATES(2), .BASE_ADDR(32'h0)
    ) u_ws2 (
        .clock(clock), .reset(reset),
        .req_read(rd2), .req_write(wr2),
        .req_addr(addr), .req_write_data(wdata),
        .req_size(size), .req_signed(sgn),
        .ready(ready2), .read_data(data2),
        .error(err2), .busy(busy2)
    );

    dmem_wait_ctrl #(
        .DATA_WIDTH(32), .DEPTH_WORDS(1024),
        .WAIT_STATES(0), .BASE_ADDR(32'h0)
    ) u_ws0 (
        .clock(clock), .reset(reset),
        .req_read(rd0), .req_write(wr0),
        .req_addr(addr), .req_write_data(wdata),
        .req_size(size), .req_signed(sgn),
        .ready(ready0), .read_data(data0),
        .error(err0), .busy(busy0)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic access(input bit z, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input bit sg,
                          input logic [31:0] ed, input bit ee,
                          input string tag);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clock);
        addr  = a;
        wdata = d;
        size  = sz;
        sgn   = sg;
        if (z) begin rd0 = rd; wr0 = wr; end
        else   begin rd2 = rd; wr2 = wr; end
        e.data = ed;
        e.err  = ee;
        sb.push_back(e);
        @(negedge clock);
        rd0 = 0; wr0 = 0; rd2 = 0; wr2 = 0;
        n = 1;
        seen = (z ? ready0 : ready2);
        while (!seen && n < 20) begin
            @(negedge clock);
            n++;
            seen = (z ? ready0 : ready2);
        end
        chk({tag, " ready-seen"}, 32'(seen), 32'd1);
        if (seen) begin
            e = sb.pop_front();
            chk({tag, " latency"}, n, z ? 32'd1 : 32'd3);
            chk({tag, " data"}, z ? data0 : data2, e.data);
            chk({tag, " error"}, 32'(z ? err0 : err2), 32'(e.err));
            chk({tag, " busy"}, 32'(z ? busy0 : busy2), 32'd1);
            @(negedge clock);
            chk({tag, " ready-drop"}, 32'(z ? ready0 : ready2), 32'd0);
            chk({tag, " data-idle"}, z ? data0 : data2, 32'd0);
        end
    endtask

    task automatic abort_wr(input int rst_after, input string tag);
        int hits;
        @(negedge clock);
        addr  = 32'h20;
        wdata = 32'h1234_5678;
        size  = 2'b10;
        sgn   = 0;
        wr2   = 1;
        @(negedge clock);
        wr2 = 0;
        repeat (rst_after - 1) @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        chk({tag, " busy"}, 32'(busy2), 32'd0);
        hits = 0;
        repeat (6) begin
            @(negedge clock);
            if (ready2) hits++;
        end
        chk({tag, " no-ready"}, hits, 32'd0);
        access(0, 1, 0, 32'h20, 0, 2'b10, 0, 32'hCAFE_F00D, 0,
               {tag, " rd20"});
    endtask

    initial begin
        reset = 1;
        rd2 = 0; wr2 = 0; rd0 = 0; wr0 = 0;
        addr = 0; wdata = 0; size = 2'b10; sgn = 0;
        repeat (3) @(negedge clock);
        chk("rst ready2", 32'(ready2), 0);
        chk("rst err2", 32'(err2), 0);
        chk("rst busy2", 32'(busy2), 0);
        chk("rst data2", data2, 0);
        chk("rst ready0", 32'(ready0), 0);
        chk("rst data0", data0, 0);
        reset = 0;

        access(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, "sw10");
        access(0, 1, 0, 32'h10, 0, 2'b10, 1, 32'hDEAD_BEEF, 0, "lw10");
        access(0, 1, 0, 32'h13, 0, 2'b00, 1, 32'hFFFF_FFDE, 0, "lb13");
        access(0, 1, 0, 32'h13, 0, 2'b00, 0, 32'h0000_00DE, 0, "lbu13");
        access(0, 1, 0, 32'h12, 0, 2'b01, 1, 32'hFFFF_DEAD, 0, "lh12");
        access(0, 1, 0, 32'h10, 0, 2'b01, 1, 32'hFFFF_BEEF, 0, "lh10");
        access(0, 1, 0, 32'h10, 0, 2'b01, 0, 32'h0000_BEEF, 0, "lhu10");
        access(0, 0, 1, 32'h11, 32'hAABB_CC55, 2'b00, 0, 0, 0, "sb11");
        access(0, 1, 0, 32'h10, 0, 2'b10, 0, 32'hDEAD_55EF, 0, "lw10b");
        access(0, 0, 1, 32'h0, 32'h1111_2222, 2'b10, 0, 0, 0, "sw0");
        access(0, 0, 1, 32'h12, 32'h0000_7788, 2'b01, 0, 0, 0, "sh12");
        access(0, 1, 0, 32'h10, 0, 2'b10, 0, 32'h7788_55EF, 0, "lw10c");

        access(0, 0, 1, 32'h11, 32'hFFFF_FFFF, 2'b01, 0, 0, 1, "sh11");
        access(0, 1, 0, 32'h12, 0, 2'b10, 0, 0, 1, "lw12");
        access(0, 1, 0, 32'h1000, 0, 2'b10, 0, 0, 1, "lw1000");
        access(0, 0, 1, 32'h1000, 32'h9999_9999, 2'b10, 0, 0, 1,
               "sw1000");
        access(0, 1, 0, 32'hFFC, 0, 2'b10, 0, 32'hx, 0, "lwFFC");
        access(0, 0, 1, 32'h10, 32'h0, 2'b11, 0, 0, 1, "sz11");
        access(0, 1, 1, 32'h10, 32'h0, 2'b10, 0, 0, 1, "rdwr2");
        access(0, 1, 0, 32'h10, 0, 2'b10, 0, 32'h7788_55EF, 0, "lw10d");
        access(0, 1, 0, 32'h0, 0, 2'b10, 0, 32'h1111_2222, 0, "lw0");

        access(0, 0, 1, 32'h20, 32'hCAFE_F00D, 2'b10, 0, 0, 0, "sw20");
        abort_wr(1, "rst-wait");
        abort_wr(2, "rst-commit");

        access(1, 0, 1, 32'h40, 32'h0BAD_F00D, 2'b10, 0, 0, 0, "z sw40");
        @(negedge clock);
        addr = 32'h40;
        size = 2'b10;
        rd0  = 1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            chk($sformatf("b2b ready %0d", i), 32'(ready0),
                32'(i % 2));
            if (i % 2 == 1) begin
                chk($sformatf("b2b data %0d", i), data0,
                    32'h0BAD_F00D);
            end
        end
        rd0 = 0;
        access(1, 1, 1, 32'h40, 32'hFFFF_FFFF, 2'b10, 0, 0, 1,
               "z rdwr");
        access(1, 1, 0, 32'h40, 0, 2'b10, 0, 32'h0BAD_F00D, 0, "z lw40");
        access(1, 1, 0, 32'h43, 0, 2'b00, 0, 32'h0000_000B, 0, "z lbu43");

        chk("sb empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_wait_ctrl.md
Name: dmem_wait_ctrl

Overview:
Parametrised data-memory block that succeeds the single-cycle data memory wired beside the mips32 core. It adds a request/ready handshake with a configurable number of wait states, so the core can be stalled. It supports byte, halfword and word accesses with sign or zero extension, and flags misaligned or out-of-range accesses. It sits between the core's dmem port and the word-organised storage array, which is internal to this block.

Parameters:
DATA_WIDTH, 32, word width in bits; fixed at 32, byte lanes derived from it
DEPTH_WORDS, 1024, number of words of storage
WAIT_STATES, 2, extra cycles inserted before ready; legal range 0..15
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_read  input  1  read request; sampled only in IDLE
req_write  input  1  write request; sampled only in IDLE
req_addr  input  32  byte address
req_write_data  input  32  store data; right-aligned (byte in [7:0], halfword in [15:0])
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  input  1  1 sign-extends loads, 0 zero-extends
ready  output  1  one-cycle pulse marking access completion
read_data  output  32  load result; valid only while ready=1
error  output  1  pulses together with ready when the access was rejected
busy  output  1  high while in WAIT or DONE

Behaviour:
- Reset (synchronous): state goes to IDLE; ready=0, error=0, busy=0, read_data=0, wait counter=0. Storage contents are not cleared.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If req_read or req_write is high, latch addr, write data, size, signed flag and direction.
  - If WAIT_STATES>0, go to WAIT with counter=WAIT_STATES-1; otherwise go directly to DONE.
  - If both req_read and req_write are high, the access is rejected (illegal), and the same latency still applies.
- WAIT: counter decrements each cycle; at counter==0 go to DONE.
- DONE (one cycle): ready=1, then return to IDLE.
  - Latency from request-sampling edge to ready is WAIT_STATES+1 cycles.
  - Inputs are ignored in DONE. A new request is sampled no earlier than the cycle after ready.
  - Maximum throughput is one access per WAIT_STATES+2 cycles.
- Address decode:
  - offset = req_addr - BASE_ADDR; word index = offset[31:2]; lane = offset[1:0]; little-endian lanes.
  - Rejected (error=1 with ready) when any of the following holds:
    - word index >= DEPTH_WORDS, or req_addr < BASE_ADDR;
    - halfword access with lane[0]=1;
    - word access with lane!=0;
    - req_size=11;
    - simultaneous read and write.
- Write commit:
  - Only the addressed byte lanes change, on the edge that enters DONE.
  - Rejected writes modify nothing.
- Read:
  - Selected lanes are shifted to the LSBs and extended per req_signed.
  - Word reads ignore req_signed.
  - read_data is registered and presented in DONE.
  - A rejected read returns read_data=0.
  - Outside DONE, read_data holds 0.
- Reset mid-operation:
  - Reset in WAIT or DONE aborts the access; no ready pulse follows.
  - If reset coincides with the commit edge, reset wins and no write occurs.
- Request inputs may change freely while busy=1; only the values latched in IDLE matter.

Test Plan:
- WAIT_STATES=2, BASE_ADDR=0: write word 0xDEADBEEF to 0x10, then read word 0x10 -> ready exactly 3 cycles after each request edge; read_data=0xDEADBEEF, error=0.
- After that write, load byte 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE. Load halfword 0x12 signed -> 0xFFFFDEAD.
- Store byte 0x55 to 0x11, then word read of 0x10 -> 0xDEAD55EF; other lanes unchanged.
- Halfword write to 0x11, word read of 0x12, and address 0x1000 with DEPTH_WORDS=1024 -> error=1 with ready, read_data=0, memory unchanged.
- WAIT_STATES=0: back-to-back requests held high -> ready every 2nd cycle. Simultaneous req_read and req_write -> error pulse.
- Assert reset one cycle into a WAIT for a write of 0x12345678 to 0x20 -> no ready pulse; a later read of 0x20 returns the prior value.
